// File: rtl/jesd204_tx_ctrl_pkg.sv
// Shared definitions for the JESD204 TX multi-link controller.
// Contents: per-link state width and state encodings.
package jesd204_tx_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] STATE_WAIT = 2'd0;
  localparam logic [STATE_W-1:0] STATE_CGS  = 2'd1;
  localparam logic [STATE_W-1:0] STATE_ILAS = 2'd2;
  localparam logic [STATE_W-1:0] STATE_DATA = 2'd3;

endpackage

// File: rtl/jesd204_tx_link_fsm.sv
// Per-link SYNC~ request filter, CGS/ILAS/DATA state machine and ILAS
// multiframe counter.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   sync_status              synchronised SYNC~ for this link (active low)
//   lmfc_edge                one-cycle LMFC boundary pulse
//   link_disable             link ignored, held in WAIT
//   force_request            manual / continuous request, bypasses the filter
//   cfg_skip_ilas            CGS goes straight to DATA
//   cfg_mframes_per_ilas     ILAS length minus one, in multiframes
//   cfg_sync_filter_cycles   SYNC~ qualification length
//   state                    registered state
//   state_next_c             next state (combinational, for registered lane outputs)
//   ilas_mframe              registered ILAS multiframe index (0 outside ILAS)
//   tx_ready                 registered, link in DATA
module jesd204_tx_link_fsm
  import jesd204_tx_ctrl_pkg::*;
#(
  parameter int unsigned MF_COUNTER_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sync_status,
  input  logic                        lmfc_edge,
  input  logic                        link_disable,
  input  logic                        force_request,
  input  logic                        cfg_skip_ilas,
  input  logic [MF_COUNTER_WIDTH-1:0] cfg_mframes_per_ilas,
  input  logic [7:0]                  cfg_sync_filter_cycles,
  output logic [STATE_W-1:0]          state,
  output logic [STATE_W-1:0]          state_next_c,
  output logic [MF_COUNTER_WIDTH-1:0] ilas_mframe,
  output logic                        tx_ready
);

  logic [7:0]                  filt_cnt_q, filt_cnt_d;
  logic                        filt_req_q, filt_req_d;
  logic                        sync_request_c;
  logic [STATE_W-1:0]          state_q, state_d;
  logic [MF_COUNTER_WIDTH-1:0] mf_q, mf_d;
  logic                        tx_ready_q;

  // State, filter and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_q <= 8'd0;
      filt_req_q <= 1'b0;
      state_q    <= STATE_WAIT;
      mf_q       <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      filt_req_q <= filt_req_d;
      state_q    <= state_d;
      mf_q       <= mf_d;
      tx_ready_q <= (state_d == STATE_DATA);
    end
  end

  // Request filter and next-state logic
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_req_d = 1'b0;
    state_d    = state_q;
    mf_d       = mf_q;

    // Low SYNC~ must persist until the counter reaches the threshold; any
    // high sample drops the request immediately. >= guards against the
    // threshold being lowered below the running count.
    if (link_disable || sync_status) begin
      filt_cnt_d = 8'd0;
    end else begin
      filt_req_d = (filt_cnt_q >= cfg_sync_filter_cycles);
      if (filt_cnt_q < cfg_sync_filter_cycles) begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end

    sync_request_c = ~link_disable & (filt_req_q | force_request);

    // Request outranks a coincident LMFC edge in every state
    if (link_disable) begin
      state_d = STATE_WAIT;
      mf_d    = '0;
    end else if (sync_request_c) begin
      state_d = STATE_CGS;
      mf_d    = '0;
    end else begin
      case (state_q)
        STATE_CGS: begin
          mf_d = '0;
          if (lmfc_edge) begin
            state_d = cfg_skip_ilas ? STATE_DATA : STATE_ILAS;
          end
        end
        STATE_ILAS: begin
          if (lmfc_edge) begin
            if (mf_q >= cfg_mframes_per_ilas) begin
              state_d = STATE_DATA;
              mf_d    = '0;
            end else begin
              mf_d = mf_q + MF_COUNTER_WIDTH'(1);
            end
          end
        end
        STATE_DATA: begin
          mf_d = '0;
        end
        default: begin
          state_d = STATE_WAIT;
          mf_d    = '0;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign state_next_c = state_d;
  assign ilas_mframe  = mf_q;
  assign tx_ready     = tx_ready_q;

endmodule

// File: rtl/jesd204_tx_multilink_ctrl.sv
// JESD204 TX link controller for several independent links sharing one lane
// group. Synchronises SYNC~, runs one link FSM per link, maps contiguous lane
// groups to links and reduces per-link readiness into tx_ready.
// Optional feature macro: JESD204_TX_RESYNC_CNT_EN adds per-link saturating
// DATA -> CGS resync counters (status_resync_count, ctrl_resync_count_clear).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   sync                        raw SYNC~ per link, asynchronous, active low
//   lmfc_edge                   LMFC boundary pulse
//   cfg_*                       static configuration
//   ctrl_manual_sync_request    per-link forced request
//   lane_cgs_enable / lane_ilas_enable   per-lane framer controls
//   link_ilas_mframe            per-link ILAS multiframe index
//   link_tx_ready / tx_ready    per-link / aggregate DATA flags
//   status_sync / status_state  synchronised SYNC~, per-link state code
module jesd204_tx_multilink_ctrl
  import jesd204_tx_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES        = 4,
  parameter int unsigned NUM_LINKS        = 2,
  parameter int unsigned MF_COUNTER_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_LINKS-1:0]                  sync,
  input  logic                                  lmfc_edge,
  input  logic [NUM_LINKS-1:0]                  cfg_links_disable,
  input  logic [NUM_LANES-1:0]                  cfg_lanes_disable,
  input  logic                                  cfg_continuous_cgs,
  input  logic                                  cfg_skip_ilas,
  input  logic [MF_COUNTER_WIDTH-1:0]           cfg_mframes_per_ilas,
  input  logic [7:0]                            cfg_sync_filter_cycles,
  input  logic [NUM_LINKS-1:0]                  ctrl_manual_sync_request,
`ifdef JESD204_TX_RESYNC_CNT_EN
  input  logic [NUM_LINKS-1:0]                  ctrl_resync_count_clear,
  output logic [NUM_LINKS*8-1:0]                status_resync_count,
`endif
  output logic [NUM_LANES-1:0]                  lane_cgs_enable,
  output logic [NUM_LANES-1:0]                  lane_ilas_enable,
  output logic [NUM_LINKS*MF_COUNTER_WIDTH-1:0] link_ilas_mframe,
  output logic [NUM_LINKS-1:0]                  link_tx_ready,
  output logic                                  tx_ready,
  output logic [NUM_LINKS-1:0]                  status_sync,
  output logic [2*NUM_LINKS-1:0]                status_state
);

  localparam int unsigned LPL = NUM_LANES / NUM_LINKS;

  logic [NUM_LINKS-1:0]        sync_meta_q, sync_q;
  logic [STATE_W-1:0]          link_state [NUM_LINKS];
  logic [STATE_W-1:0]          link_next  [NUM_LINKS];
  logic [NUM_LANES-1:0]        lane_cgs_d, lane_ilas_d;
  logic [NUM_LANES-1:0]        lane_cgs_q, lane_ilas_q;
  logic                        any_enabled_c, all_data_c;
  logic                        tx_ready_q;

  // Two-flop SYNC~ synchroniser; idles high (no request)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= '1;
      sync_q      <= '1;
    end else begin
      sync_meta_q <= sync;
      sync_q      <= sync_meta_q;
    end
  end

  assign status_sync = sync_q;

  // Per-link controllers
  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
    jesd204_tx_link_fsm #(
      .MF_COUNTER_WIDTH (MF_COUNTER_WIDTH)
    ) u_link_fsm (
      .clk                    (clk),
      .reset                  (reset),
      .sync_status            (sync_q[k]),
      .lmfc_edge              (lmfc_edge),
      .link_disable           (cfg_links_disable[k]),
      .force_request          (ctrl_manual_sync_request[k] | cfg_continuous_cgs),
      .cfg_skip_ilas          (cfg_skip_ilas),
      .cfg_mframes_per_ilas   (cfg_mframes_per_ilas),
      .cfg_sync_filter_cycles (cfg_sync_filter_cycles),
      .state                  (link_state[k]),
      .state_next_c           (link_next[k]),
      .ilas_mframe            (link_ilas_mframe[k*MF_COUNTER_WIDTH +: MF_COUNTER_WIDTH]),
      .tx_ready               (link_tx_ready[k])
    );

    assign status_state[k*STATE_W +: STATE_W] = link_state[k];
  end

  // Lane l is owned by link l/LPL; decoded from next state so the lane
  // registers change on the same edge as the owning state register.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int unsigned OWNER = l / LPL;
    assign lane_cgs_d[l]  = cfg_lanes_disable[l] |
                            (link_next[OWNER] == STATE_WAIT) |
                            (link_next[OWNER] == STATE_CGS);
    assign lane_ilas_d[l] = ~cfg_lanes_disable[l] & (link_next[OWNER] == STATE_ILAS);
  end

  // Ready only when at least one link is enabled and all enabled are in DATA
  always_comb begin
    any_enabled_c = 1'b0;
    all_data_c    = 1'b1;
    for (int k = 0; k < NUM_LINKS; k++) begin
      if (!cfg_links_disable[k]) begin
        any_enabled_c = 1'b1;
        if (link_next[k] != STATE_DATA) begin
          all_data_c = 1'b0;
        end
      end
    end
  end

  // Lane enables and aggregate ready
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cgs_q  <= '1;
      lane_ilas_q <= '0;
      tx_ready_q  <= 1'b0;
    end else begin
      lane_cgs_q  <= lane_cgs_d;
      lane_ilas_q <= lane_ilas_d;
      tx_ready_q  <= any_enabled_c & all_data_c;
    end
  end

  assign lane_cgs_enable  = lane_cgs_q;
  assign lane_ilas_enable = lane_ilas_q;
  assign tx_ready         = tx_ready_q;

`ifdef JESD204_TX_RESYNC_CNT_EN
  // Saturating DATA -> CGS counters; clear wins over increment
  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_resync
    logic [7:0] resync_cnt_q;

    always_ff @(posedge clk) begin
      if (reset || ctrl_resync_count_clear[k]) begin
        resync_cnt_q <= 8'd0;
      end else if ((link_state[k] == STATE_DATA) && (link_next[k] == STATE_CGS) &&
                   (resync_cnt_q != 8'hFF)) begin
        resync_cnt_q <= resync_cnt_q + 8'd1;
      end
    end

    assign status_resync_count[k*8 +: 8] = resync_cnt_q;
  end
`endif

endmodule

// File: tb/tb_jesd204_tx_multilink_ctrl.sv
// Directed self-checking bench for jesd204_tx_multilink_ctrl (4 lanes, 2 links).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jesd204_tx_multilink_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  sync;
  logic        lmfc_edge;
  logic [1:0]  cfg_links_disable;
  logic [3:0]  cfg_lanes_disable;
  logic        cfg_continuous_cgs;
  logic        cfg_skip_ilas;
  logic [7:0]  cfg_mframes_per_ilas;
  logic [7:0]  cfg_sync_filter_cycles;
  logic [1:0]  ctrl_manual_sync_request;
  logic [3:0]  lane_cgs_enable;
  logic [3:0]  lane_ilas_enable;
  logic [15:0] link_ilas_mframe;
  logic [1:0]  link_tx_ready;
  logic        tx_ready;
  logic [1:0]  status_sync;
  logic [3:0]  status_state;
`ifdef JESD204_TX_RESYNC_CNT_EN
  logic [1:0]  ctrl_resync_count_clear;
  logic [15:0] status_resync_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  jesd204_tx_multilink_ctrl #(
    .NUM_LANES        (4),
    .NUM_LINKS        (2),
    .MF_COUNTER_WIDTH (8)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .sync                     (sync),
    .lmfc_edge                (lmfc_edge),
    .cfg_links_disable        (cfg_links_disable),
    .cfg_lanes_disable        (cfg_lanes_disable),
    .cfg_continuous_cgs       (cfg_continuous_cgs),
    .cfg_skip_ilas            (cfg_skip_ilas),
    .cfg_mframes_per_ilas     (cfg_mframes_per_ilas),
    .cfg_sync_filter_cycles   (cfg_sync_filter_cycles),
    .ctrl_manual_sync_request (ctrl_manual_sync_request),
`ifdef JESD204_TX_RESYNC_CNT_EN
    .ctrl_resync_count_clear  (ctrl_resync_count_clear),
    .status_resync_count      (status_resync_count),
`endif
    .lane_cgs_enable          (lane_cgs_enable),
    .lane_ilas_enable         (lane_ilas_enable),
    .link_ilas_mframe         (link_ilas_mframe),
    .link_tx_ready            (link_tx_ready),
    .tx_ready                 (tx_ready),
    .status_sync              (status_sync),
    .status_state             (status_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle LMFC pulse; returns on the falling edge after it was sampled
  task automatic lmfc_pulse();
    lmfc_edge = 1'b1;
    @(negedge clk);
    lmfc_edge = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                    = 1'b1;
    sync                     = 2'b11;
    lmfc_edge                = 1'b0;
    cfg_links_disable        = 2'b00;
    cfg_lanes_disable        = 4'b0000;
    cfg_continuous_cgs       = 1'b0;
    cfg_skip_ilas            = 1'b0;
    cfg_mframes_per_ilas     = 8'd3;
    cfg_sync_filter_cycles   = 8'd3;
    ctrl_manual_sync_request = 2'b00;
`ifdef JESD204_TX_RESYNC_CNT_EN
    ctrl_resync_count_clear  = 2'b00;
`endif
    tick(3);
    chk("rst_state",    32'(status_state),     32'h0);
    chk("rst_lane_cgs", 32'(lane_cgs_enable),  32'hF);
    chk("rst_tx_ready", 32'(tx_ready),         32'h0);
    chk("rst_sync",     32'(status_sync),      32'h3);
    chk("rst_mframe",   32'(link_ilas_mframe), 32'h0);

    // Idle with SYNC~ high: stays in WAIT
    reset = 1'b0;
    tick(20);
    chk("idle_state",     32'(status_state),     32'h0);
    chk("idle_lane_cgs",  32'(lane_cgs_enable),  32'hF);
    chk("idle_lane_ilas", 32'(lane_ilas_enable), 32'h0);
    chk("idle_tx_ready",  32'(tx_ready),         32'h0);
    chk("idle_link_rdy",  32'(link_tx_ready),    32'h0);

    // Longest sub-threshold pulse (3 samples low, filter 3) is rejected
    sync = 2'b10;
    tick(3);
    sync = 2'b11;
    tick(12);
    chk("short_pulse_wait", 32'(status_state), 32'h0);

    // Qualified request: CGS 2+3+1+1 = 7 edges after SYNC~ falls
    sync = 2'b10;
    tick(1);
    chk("sync_lag_1", 32'(status_sync), 32'h3);
    tick(1);
    chk("sync_lag_2", 32'(status_sync), 32'h2);
    tick(4);
    chk("filter_edge6_wait", 32'(status_state), 32'h0);
    tick(1);
    chk("filter_edge7_cgs", 32'(status_state), 32'h1);
    tick(1);
    sync = 2'b11;
    tick(5);
    chk("cgs_hold",     32'(status_state),    32'h1);
    chk("cgs_lane_cgs", 32'(lane_cgs_enable), 32'hF);

    // ILAS with 4 multiframes, LMFC period 16
    lmfc_pulse();
    chk("ilas_state",     32'(status_state),          32'h2);
    chk("ilas_lane_ilas", 32'(lane_ilas_enable),      32'h3);
    chk("ilas_lane_cgs",  32'(lane_cgs_enable),       32'hC);
    chk("ilas_mframe_0",  32'(link_ilas_mframe[7:0]), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick(15);
      lmfc_pulse();
      chk("ilas_mframe_step", 32'(link_ilas_mframe[7:0]), 32'(i));
      chk("ilas_state_step",  32'(status_state),          32'h2);
    end
    tick(15);
    lmfc_pulse();
    chk("data_state",     32'(status_state),     32'h3);
    chk("data_link_rdy",  32'(link_tx_ready),    32'h1);
    chk("data_tx_ready",  32'(tx_ready),         32'h0);
    chk("data_lane_ilas", 32'(lane_ilas_enable), 32'h0);
    chk("data_mframe",    32'(link_ilas_mframe), 32'h0);

    // Link 1 via manual request, single-multiframe ILAS
    cfg_mframes_per_ilas     = 8'd0;
    ctrl_manual_sync_request = 2'b10;
    tick(1);
    ctrl_manual_sync_request = 2'b00;
    chk("l1_manual_cgs", 32'(status_state), 32'h7);
    tick(2);
    lmfc_pulse();
    chk("l1_ilas_state", 32'(status_state),     32'hB);
    chk("l1_lane_ilas",  32'(lane_ilas_enable), 32'hC);
    tick(15);
    lmfc_pulse();
    chk("both_data_state", 32'(status_state),    32'hF);
    chk("both_tx_ready",   32'(tx_ready),        32'h1);
    chk("both_link_rdy",   32'(link_tx_ready),   32'h3);
    chk("both_lane_cgs",   32'(lane_cgs_enable), 32'h0);

    // Unfiltered resync on link 1: CGS 4 edges after SYNC~ falls
    cfg_sync_filter_cycles = 8'd0;
    sync = 2'b01;
    tick(3);
    chk("resync_pre_rdy",   32'(link_tx_ready), 32'h3);
    chk("resync_pre_txrdy", 32'(tx_ready),      32'h1);
    tick(1);
    chk("resync_state",    32'(status_state),    32'h7);
    chk("resync_link_rdy", 32'(link_tx_ready),   32'h1);
    chk("resync_tx_ready", 32'(tx_ready),        32'h0);
    chk("resync_lane_cgs", 32'(lane_cgs_enable), 32'hC);
`ifdef JESD204_TX_RESYNC_CNT_EN
    chk("resync_count", 32'(status_resync_count), 32'h0100);
`endif
    sync = 2'b11;
    tick(4);

    // Link 1 disabled, skip ILAS: tx_ready follows link 0 alone
    cfg_links_disable        = 2'b10;
    cfg_skip_ilas            = 1'b1;
    ctrl_manual_sync_request = 2'b01;
    tick(1);
    ctrl_manual_sync_request = 2'b00;
    chk("dis_state_cgs", 32'(status_state),    32'h1);
    chk("dis_tx_ready0", 32'(tx_ready),        32'h0);
    chk("dis_lane_cgs",  32'(lane_cgs_enable), 32'hF);
    tick(2);
    lmfc_pulse();
    chk("skip_state",     32'(status_state),     32'h3);
    chk("skip_tx_ready",  32'(tx_ready),         32'h1);
    chk("skip_link_rdy",  32'(link_tx_ready),    32'h1);
    chk("skip_lane_cgs",  32'(lane_cgs_enable),  32'hC);
    chk("skip_lane_ilas", 32'(lane_ilas_enable), 32'h0);
    cfg_lanes_disable = 4'b0010;
    tick(1);
    chk("lane_dis_cgs", 32'(lane_cgs_enable), 32'hE);
    cfg_lanes_disable = 4'b0000;
    cfg_links_disable = 2'b11;
    tick(1);
    chk("all_dis_tx_ready", 32'(tx_ready),        32'h0);
    chk("all_dis_state",    32'(status_state),    32'h0);
    chk("all_dis_lane_cgs", 32'(lane_cgs_enable), 32'hF);

    // Reset in the middle of ILAS
    cfg_links_disable        = 2'b00;
    cfg_skip_ilas            = 1'b0;
    cfg_mframes_per_ilas     = 8'd3;
    ctrl_manual_sync_request = 2'b01;
    tick(1);
    ctrl_manual_sync_request = 2'b00;
    tick(2);
    lmfc_pulse();
    chk("pre_rst_ilas", 32'(status_state),     32'h2);
    chk("pre_rst_lane", 32'(lane_ilas_enable), 32'h3);
    tick(15);
    lmfc_pulse();
    chk("pre_rst_mframe", 32'(link_ilas_mframe), 32'h1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_state",     32'(status_state),     32'h0);
    chk("mid_rst_lane_cgs",  32'(lane_cgs_enable),  32'hF);
    chk("mid_rst_lane_ilas", 32'(lane_ilas_enable), 32'h0);
    chk("mid_rst_mframe",    32'(link_ilas_mframe), 32'h0);
    chk("mid_rst_link_rdy",  32'(link_tx_ready),    32'h0);
    chk("mid_rst_tx_ready",  32'(tx_ready),         32'h0);
    reset = 1'b0;
    tick(2);

    // Request with a coincident LMFC edge lands in CGS, not DATA
    cfg_skip_ilas = 1'b1;
    sync = 2'b10;
    tick(3);
    lmfc_edge = 1'b1;
    tick(1);
    lmfc_edge = 1'b0;
    chk("req_vs_edge_cgs", 32'(status_state), 32'h1);
    tick(3);
    lmfc_pulse();
    chk("held_req_vs_edge", 32'(status_state), 32'h1);
    sync = 2'b11;
    tick(4);
    lmfc_pulse();
    chk("final_state",    32'(status_state), 32'h3);
    chk("final_tx_ready", 32'(tx_ready),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
